// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler paces the digit scan; the display inputs are captured once per
// frame so a value can never tear across digits. Leading-zero blanking,
// per-digit decimal points and per-digit blink are applied per slot.
//
// Ports
//   clk_i         system clock, rising edge
//   reset_ni      synchronous active-low reset
//   bcd_i         packed BCD, [3:0] = digit 0 (rightmost), nibbles 10..15 show A..F
//   dp_en_i       decimal point enable, bit i = digit i
//   blank_lz_i    1 enables leading-zero blanking
//   blink_mask_i  1 makes digit i blink
//   seg_7_o       active-low segments {p,g,f,e,d,c,b,a}
//   com_o         active-low one-hot digit commons, bit i = digit i
module fnd_scan_controller #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned BLINK_SCANS = 125
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [15:0] bcd_i,
  input  logic [3:0]  dp_en_i,
  input  logic        blank_lz_i,
  input  logic [3:0]  blink_mask_i,
  output logic [7:0]  seg_7_o,
  output logic [3:0]  com_o
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned FW = $clog2(BLINK_SCANS) + 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_SCANS - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    digitIdx_q, digitIdx_d;
  logic [FW-1:0] frameCnt_q, frameCnt_d;
  logic          phase_q, phase_d;
  logic [15:0]   bcdSnap_q, bcdSnap_d;
  logic [3:0]    dpSnap_q, dpSnap_d;
  logic          blankSnap_q, blankSnap_d;
  logic [3:0]    blinkSnap_q, blinkSnap_d;
  logic          phaseSnap_q, phaseSnap_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    com_q, com_d;

  logic       tick;
  logic       frameStart;
  logic [3:0] nibble;
  logic [3:0] blankVec;
  logic [7:0] segNext;

  function automatic logic [6:0] glyph7(input logic [3:0] n);
    case (n)
      4'h0:    glyph7 = 7'h40;
      4'h1:    glyph7 = 7'h79;
      4'h2:    glyph7 = 7'h24;
      4'h3:    glyph7 = 7'h30;
      4'h4:    glyph7 = 7'h19;
      4'h5:    glyph7 = 7'h12;
      4'h6:    glyph7 = 7'h02;
      4'h7:    glyph7 = 7'h58;
      4'h8:    glyph7 = 7'h00;
      4'h9:    glyph7 = 7'h18;
      4'hA:    glyph7 = 7'h08;
      4'hB:    glyph7 = 7'h03;
      4'hC:    glyph7 = 7'h46;
      4'hD:    glyph7 = 7'h21;
      4'hE:    glyph7 = 7'h06;
      default: glyph7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick        = (prescaler_q == PRE_LAST);
    frameStart  = tick && (digitIdx_q == 2'd3);
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    digitIdx_d  = tick ? digitIdx_q + 2'd1 : digitIdx_q;

    // The _d snapshot values double as the "effective" frame values, so
    // digit 0 on the frame-start edge already sees the freshly captured inputs.
    bcdSnap_d   = frameStart ? bcd_i        : bcdSnap_q;
    dpSnap_d    = frameStart ? dp_en_i      : dpSnap_q;
    blankSnap_d = frameStart ? blank_lz_i   : blankSnap_q;
    blinkSnap_d = frameStart ? blink_mask_i : blinkSnap_q;

    // The blink phase for a whole frame is the phase before this frame's
    // counter update, so every slot of one frame agrees on visibility.
    phaseSnap_d = frameStart ? phase_q : phaseSnap_q;
    frameCnt_d  = frameCnt_q;
    phase_d     = phase_q;
    if (frameStart) begin
      if (frameCnt_q == FRAME_LAST) begin
        frameCnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        frameCnt_d = frameCnt_q + FW'(1);
      end
    end

    nibble = bcdSnap_d[{digitIdx_d, 2'b00} +: 4];

    // A digit is a leading zero when it and every higher nibble are zero.
    blankVec[3] = (bcdSnap_d[15:12] == 4'h0);
    blankVec[2] = blankVec[3] && (bcdSnap_d[11:8] == 4'h0);
    blankVec[1] = blankVec[2] && (bcdSnap_d[7:4] == 4'h0);
    blankVec[0] = 1'b0;
    blankVec    = blankVec & {4{blankSnap_d}};

    if (!phaseSnap_d && blinkSnap_d[digitIdx_d]) begin
      segNext = 8'hFF;
    end else if (blankVec[digitIdx_d]) begin
      segNext = {~dpSnap_d[digitIdx_d], 7'h7F};
    end else begin
      segNext = {~dpSnap_d[digitIdx_d], glyph7(nibble)};
    end

    com_d = tick ? ~(4'b0001 << digitIdx_d) : com_q;
    seg_d = tick ? segNext : seg_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      prescaler_q <= '0;
      digitIdx_q  <= 2'd3;
      frameCnt_q  <= '0;
      phase_q     <= 1'b1;
      bcdSnap_q   <= '0;
      dpSnap_q    <= '0;
      blankSnap_q <= 1'b0;
      blinkSnap_q <= '0;
      phaseSnap_q <= 1'b1;
      seg_q       <= 8'hFF;
      com_q       <= 4'hF;
    end else begin
      prescaler_q <= prescaler_d;
      digitIdx_q  <= digitIdx_d;
      frameCnt_q  <= frameCnt_d;
      phase_q     <= phase_d;
      bcdSnap_q   <= bcdSnap_d;
      dpSnap_q    <= dpSnap_d;
      blankSnap_q <= blankSnap_d;
      blinkSnap_q <= blinkSnap_d;
      phaseSnap_q <= phaseSnap_d;
      seg_q       <= seg_d;
      com_q       <= com_d;
    end
  end

  assign seg_7_o = seg_q;
  assign com_o   = com_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller
// Directed and randomized stimulus for fnd_scan_controller (SCAN_DIV=4,
// BLINK_SCANS=2). Expected outputs come from a cycle-counting reference that
// derives the slot, frame number and blink phase arithmetically from the
// number of clocks since reset release.
module tb_fnd_scan_controller;

  localparam int SCAN_DIV    = 4;
  localparam int BLINK_SCANS = 2;

  logic        clk;
  logic        resetN;
  logic [15:0] bcd;
  logic [3:0]  dpEn;
  logic        blankLz;
  logic [3:0]  blinkMask;
  logic [7:0]  seg7;
  logic [3:0]  com;

  fnd_scan_controller #(
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_SCANS (BLINK_SCANS)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (resetN),
    .bcd_i        (bcd),
    .dp_en_i      (dpEn),
    .blank_lz_i   (blankLz),
    .blink_mask_i (blinkMask),
    .seg_7_o      (seg7),
    .com_o        (com)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] glyphTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
                                  8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int         errors = 0;
  int         checks = 0;
  string      tag = "reset";
  int         cyc = 0;
  logic [15:0] snapBcd = '0;
  logic [3:0]  snapDp = '0;
  logic        snapBlank = 1'b0;
  logic [3:0]  snapMask = '0;
  logic [3:0]  expCom = 4'hF;
  logic [7:0]  expSeg = 8'hFF;

  // Reference glyph for a slot, from the frame snapshot and frame number.
  function automatic logic [7:0] refSeg(input int slot, input int frame);
    logic [7:0]  s;
    logic [15:0] upper;
    upper = snapBcd >> (4 * slot);
    if (snapMask[slot] && ((frame / BLINK_SCANS) % 2 == 1)) return 8'hFF;
    if (snapBlank && slot > 0 && upper == 16'h0) s = 8'hFF;
    else s = glyphTable[upper[3:0]];
    if (snapDp[slot]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic checkOutput();
    checks++;
    assert (com === expCom) else begin
      errors++;
      $error("[TB] FAIL %s com: observed %b expected %b (cycle %0d)", tag, com, expCom, cyc);
    end
    checks++;
    assert (seg7 === expSeg) else begin
      errors++;
      $error("[TB] FAIL %s seg_7: observed %h expected %h (cycle %0d)", tag, seg7, expSeg, cyc);
    end
  endtask

  // Advance n clocks, updating the reference at each rising edge and checking
  // on the following falling edge.
  task automatic applyStimulus(input int n);
    int tickNum, slot, frame;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!resetN) begin
        cyc    = 0;
        expCom = 4'hF;
        expSeg = 8'hFF;
      end else begin
        cyc++;
        if (cyc % SCAN_DIV == 0) begin
          tickNum = cyc / SCAN_DIV;
          slot    = (tickNum - 1) % 4;
          frame   = (tickNum - 1) / 4;
          if (slot == 0) begin
            snapBcd   = bcd;
            snapDp    = dpEn;
            snapBlank = blankLz;
            snapMask  = blinkMask;
          end
          expCom = ~(4'b0001 << slot);
          expSeg = refSeg(slot, frame);
        end
      end
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic waitForCom(input logic [3:0] target);
    for (int i = 0; i < 24 && expCom !== target; i++) applyStimulus(1);
    checks++;
    assert (com === target) else begin
      errors++;
      $error("[TB] FAIL %s wait-com: observed %b expected %b", tag, com, target);
    end
  endtask

  task automatic pulseReset(input int n);
    resetN = 1'b0;
    applyStimulus(n);
    resetN = 1'b1;
  endtask

  initial begin
    resetN    = 1'b0;
    bcd       = 16'h1234;
    dpEn      = 4'h0;
    blankLz   = 1'b0;
    blinkMask = 4'h0;
    @(negedge clk);

    $display("[TB] basic scan");
    tag = "reset";
    applyStimulus(3);
    resetN = 1'b1;
    tag = "scan";
    applyStimulus(40);

    $display("[TB] leading-zero blanking");
    tag = "lz0050";
    bcd = 16'h0050; blankLz = 1'b1; dpEn = 4'b1000;
    applyStimulus(36);
    tag = "lz0000";
    bcd = 16'h0000;
    applyStimulus(36);

    $display("[TB] snapshot");
    tag = "snap";
    bcd = 16'h1111; blankLz = 1'b0; dpEn = 4'h0;
    applyStimulus(20);
    waitForCom(4'b1101);
    bcd = 16'h2222;
    applyStimulus(32);

    $display("[TB] blink");
    tag = "blink";
    bcd = 16'h0008; blinkMask = 4'b0001;
    pulseReset(2);
    applyStimulus(100);
    blinkMask = 4'h0;

    $display("[TB] reset mid-scan");
    tag = "midreset";
    bcd = 16'h5678;
    applyStimulus(8);
    waitForCom(4'b1011);
    pulseReset(1);
    applyStimulus(24);

    $display("[TB] hex sweep");
    tag = "hex";
    for (int n = 10; n < 16; n++) begin
      bcd = 16'(n);
      applyStimulus(16);
    end

    $display("[TB] random");
    tag = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bcd       = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
        dpEn      = 4'($urandom_range(0, 15));
        blankLz   = 1'($urandom_range(0, 1));
        blinkMask = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 299) == 0) pulseReset(1);
      applyStimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
